traffic_phase_scheduler: RTL and testbench
==========================================

Name: traffic_phase_scheduler

Overview:
Sequences a single intersection through RED, PEDESTRIAN, GREEN, YELLOW and EMERGENCY phases on a slow tick enable. It latches pedestrian call requests and services them after RED. Emergency requests preempt the normal cycle, with a mandatory YELLOW clearance out of GREEN. It drives the phase code and a one-hot lamp bus consumed by the lamp driver; phase encoding matches the team's existing traffic FSM (RED=0, PEDESTRIAN=1, GREEN=2, YELLOW=3, EMERGENCY=4).

Parameters:
RED_T, 25, RED duration in ticks (>=1)
PED_T, 21, PEDESTRIAN duration in ticks (>=1)
GREEN_T, 30, GREEN duration in ticks (>=1)
YELLOW_T, 5, YELLOW duration in ticks (>=1)
EMERG_T, 21, minimum EMERGENCY duration in ticks (>=1)
CW, 8, phase counter width; every *_T must be <= 2**CW

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-low reset
tick_en  in  1  one-cycle timebase strobe; counter advances only when high
ped_req  in  1  pedestrian call, level or pulse, sampled every clk
emerg_req  in  1  emergency preempt, level; held high for as long as preemption is wanted
phase  out  3  current phase code
lamp  out  5  one-hot phase lamp: bit[phase] = 1
ped_pend  out  1  pedestrian call latched, not yet served
ped_ack  out  1  one-cycle pulse on entry to PEDESTRIAN
emerg_act  out  1  high while in EMERGENCY
remain  out  CW  ticks remaining in current phase minus 1

Behaviour:
- One clock; reset is synchronous and active-low. All state changes occur on posedge clk; rst=0 overrides all other inputs.
- Reset values: phase=RED, lamp=5'b00001, remain=RED_T-1, ped_pend=0, ped_ack=0, emerg_act=0.
- All outputs are registered. lamp and emerg_act are decoded from the next-state value so they align with phase.
- Phase entry: remain loads DUR-1 for the new phase.
- Counting: on tick_en=1 with remain>0, remain decrements. On tick_en=1 with remain==0, the phase ends.
  - Each phase therefore lasts exactly DUR ticks when uninterrupted.
- Normal transitions at phase end:
  - RED -> PEDESTRIAN if ped_pend=1, else RED -> GREEN.
  - PEDESTRIAN -> GREEN.
  - GREEN -> YELLOW.
  - YELLOW -> RED, or YELLOW -> EMERGENCY if emerg_req=1.
- Preemption: evaluated every clk and independent of tick_en.
  - emerg_req=1 in RED or PEDESTRIAN: move to EMERGENCY on the next clk.
  - emerg_req=1 in GREEN: move to YELLOW on the next clk with a full YELLOW_T; never skip YELLOW.
  - emerg_req=1 in YELLOW: no early exit; finish YELLOW, then EMERGENCY.
- EMERGENCY exit:
  - Leave only when remain==0 AND tick_en=1 AND emerg_req=0, then go to RED.
  - If emerg_req is still high, hold at remain=0.
  - A re-asserted emerg_req during EMERGENCY does not restart the count.
- Pedestrian latch:
  - ped_pend sets on ped_req=1 in any phase except PEDESTRIAN.
  - ped_pend clears on the clk that enters PEDESTRIAN; ped_ack=1 for that single cycle.
  - ped_req during PEDESTRIAN is ignored.
  - ped_pend survives EMERGENCY and is served after the following RED.
- Simultaneous events:
  - emerg_req beats ped_pend at RED end.
  - ped_req in the same cycle that RED ends with ped_pend=0 is latched, not served; service happens on the next RED.
  - tick_en coinciding with preemption: preemption wins and remain loads the new DUR-1.
- Widths: remain is unsigned CW bits and never underflows. Phase codes 5–7 are illegal; recover to RED with remain=RED_T-1 on the next clk.

Decomposition:
- Package traffic_pkg holds:
  - phase codes RED..EMERGENCY and the phase width constant (3), shared with the existing traffic FSM and the lamp driver;
  - the lamp one-hot width (5).
- Sub-module phase_timer (CW): load/decrement/zero-flag counter with load value, load strobe and tick_en. The scheduler FSM instantiates it once.

Test Plan:
(Params RED_T=3, PED_T=2, GREEN_T=4, YELLOW_T=2, EMERG_T=2; tick_en every clk unless stated.)
- Reset: hold rst=0 for 3 clks with ped_req=emerg_req=1 -> phase=0, lamp=00001, remain=2, ped_pend=0 on every cycle; release -> RED lasts 3 clks, then GREEN for 4, YELLOW for 2, back to RED (period 9).
- Ped call: ped_req 1-clk pulse in GREEN -> ped_pend=1; after YELLOW and RED (3 clks), phase=1 with ped_ack=1 for one clk; PEDESTRIAN lasts 2 clks -> GREEN, ped_pend=0.
- Preempt from GREEN: emerg_req=1 at GREEN remain=2 -> next clk YELLOW remain=1; 2 clks later EMERGENCY; hold emerg_req for 6 clks -> stays EMERGENCY with remain=0; drop -> RED on the next tick.
- Preempt from RED with ped_pend=1 -> EMERGENCY next clk; ped_pend stays 1; after exit, RED(3) -> PEDESTRIAN served.
- Tick gating: tick_en every 4th clk -> RED lasts 12 clks; emerg_req in RED still takes effect on the next clk between ticks.
- Illegal state: force phase=6 -> next clk phase=0, remain=2, lamp=00001.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared phase encoding and lamp width for the intersection controller family.
package traffic_pkg;

  localparam int PHASE_W = 3;
  localparam int LAMP_W  = 5;

  typedef enum logic [PHASE_W-1:0] {
    PH_RED    = 3'd0,
    PH_PED    = 3'd1,
    PH_GREEN  = 3'd2,
    PH_YELLOW = 3'd3,
    PH_EMERG  = 3'd4
  } phase_e;

  // One-hot lamp for a phase code; illegal codes light nothing.
  function automatic logic [LAMP_W-1:0] lamp_decode(input logic [PHASE_W-1:0] ph);
    logic [LAMP_W-1:0] l;
    l = '0;
    case (ph)
      PH_RED:    l = 5'b00001;
      PH_PED:    l = 5'b00010;
      PH_GREEN:  l = 5'b00100;
      PH_YELLOW: l = 5'b01000;
      PH_EMERG:  l = 5'b10000;
      default:   l = '0;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Down-counter for phase duration: load wins over counting, holds at zero.
module phase_timer #(
  parameter int            CW      = 8,
  parameter logic [CW-1:0] RST_VAL = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          tick_en,
  output logic [CW-1:0] count,
  output logic          zero
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Next count: reload on phase entry, otherwise decrement on tick until zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (tick_en && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= RST_VAL;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign zero  = (count_q == '0);

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Intersection phase sequencer with pedestrian call latch and emergency preempt.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   RED       | all-red hold; serves a latched pedestrian call at its end
//   PED       | pedestrian walk phase
//   GREEN     | traffic flowing; emergency forces an early YELLOW
//   YELLOW    | clearance, always runs full length, then RED or EMERG
//   EMERG     | preempt; minimum length, held while emerg_req stays high
module traffic_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int RED_T    = 25,
  parameter int PED_T    = 21,
  parameter int GREEN_T  = 30,
  parameter int YELLOW_T = 5,
  parameter int EMERG_T  = 21,
  parameter int CW       = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick_en,
  input  logic               ped_req,
  input  logic               emerg_req,
  output logic [PHASE_W-1:0] phase,
  output logic [LAMP_W-1:0]  lamp,
  output logic               ped_pend,
  output logic               ped_ack,
  output logic               emerg_act,
  output logic [CW-1:0]      remain
);

  function automatic logic [CW-1:0] dur_m1(input logic [PHASE_W-1:0] ph);
    logic [CW-1:0] d;
    case (ph)
      PH_PED:    d = CW'(PED_T - 1);
      PH_GREEN:  d = CW'(GREEN_T - 1);
      PH_YELLOW: d = CW'(YELLOW_T - 1);
      PH_EMERG:  d = CW'(EMERG_T - 1);
      default:   d = CW'(RED_T - 1);
    endcase
    return d;
  endfunction

  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [LAMP_W-1:0]  lamp_q, lamp_d;
  logic               ped_pend_q, ped_pend_d;
  logic               ped_ack_q, ped_ack_d;
  logic               emerg_act_q, emerg_act_d;

  logic               tmr_load;
  logic [CW-1:0]      tmr_val;
  logic [CW-1:0]      tmr_count;
  logic               tmr_zero;
  logic               ph_end;

  phase_timer #(
    .CW      (CW),
    .RST_VAL (CW'(RED_T - 1))
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tick_en  (tick_en),
    .count    (tmr_count),
    .zero     (tmr_zero)
  );

  assign ph_end = tick_en && tmr_zero;

  // Next phase, timer reload and pedestrian latch; preemption ignores tick_en.
  always_comb begin
    phase_d  = phase_q;
    tmr_load = 1'b0;
    case (phase_q)
      PH_RED: begin
        if (emerg_req)       phase_d = PH_EMERG;
        else if (ph_end)     phase_d = ped_pend_q ? PH_PED : PH_GREEN;
      end
      PH_PED: begin
        if (emerg_req)       phase_d = PH_EMERG;
        else if (ph_end)     phase_d = PH_GREEN;
      end
      PH_GREEN: begin
        if (emerg_req || ph_end) phase_d = PH_YELLOW;
      end
      PH_YELLOW: begin
        if (ph_end)          phase_d = emerg_req ? PH_EMERG : PH_RED;
      end
      PH_EMERG: begin
        if (ph_end && !emerg_req) phase_d = PH_RED;
      end
      default: begin
        phase_d  = PH_RED;
        tmr_load = 1'b1;
      end
    endcase
    if (phase_d != phase_q) tmr_load = 1'b1;
    tmr_val = dur_m1(phase_d);

    ped_ack_d  = (phase_d == PH_PED) && (phase_q != PH_PED);
    ped_pend_d = ped_pend_q;
    if (ped_ack_d)                        ped_pend_d = 1'b0;
    else if (ped_req && phase_q != PH_PED) ped_pend_d = 1'b1;

    lamp_d      = lamp_decode(phase_d);
    emerg_act_d = (phase_d == PH_EMERG);
  end

  // Phase register and next-state-decoded outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      phase_q     <= PH_RED;
      lamp_q      <= 5'b00001;
      ped_pend_q  <= 1'b0;
      ped_ack_q   <= 1'b0;
      emerg_act_q <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      lamp_q      <= lamp_d;
      ped_pend_q  <= ped_pend_d;
      ped_ack_q   <= ped_ack_d;
      emerg_act_q <= emerg_act_d;
    end
  end

  assign phase     = phase_q;
  assign lamp      = lamp_q;
  assign ped_pend  = ped_pend_q;
  assign ped_ack   = ped_ack_q;
  assign emerg_act = emerg_act_q;
  assign remain    = tmr_count;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed bench for traffic_phase_scheduler with short phase durations.
module tb_traffic_phase_scheduler;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          tick_en;
  logic          ped_req;
  logic          emerg_req;
  logic [2:0]    phase;
  logic [4:0]    lamp;
  logic          ped_pend;
  logic          ped_ack;
  logic          emerg_act;
  logic [CW-1:0] remain;

  int n_assert = 0;
  int n_fail   = 0;

  traffic_phase_scheduler #(
    .RED_T(3), .PED_T(2), .GREEN_T(4), .YELLOW_T(2), .EMERG_T(2), .CW(CW)
  ) dut (
    .clk       (clk),
    .rst       (rst_n),
    .tick_en   (tick_en),
    .ped_req   (ped_req),
    .emerg_req (emerg_req),
    .phase     (phase),
    .lamp      (lamp),
    .ped_pend  (ped_pend),
    .ped_ack   (ped_ack),
    .emerg_act (emerg_act),
    .remain    (remain)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [2:0] ph, input logic [CW-1:0] rem,
                       input logic pp, input logic ack);
    logic [4:0] lp;
    logic       ea;
    lp = 5'b00001 << ph;
    ea = (ph == 3'd4);
    n_assert++;
    assert (phase === ph) else begin
      n_fail++; $error("FAIL %s phase: observed %0d expected %0d", tag, phase, ph);
    end
    n_assert++;
    assert (remain === rem) else begin
      n_fail++; $error("FAIL %s remain: observed %0d expected %0d", tag, remain, rem);
    end
    n_assert++;
    assert (lamp === lp) else begin
      n_fail++; $error("FAIL %s lamp: observed %b expected %b", tag, lamp, lp);
    end
    n_assert++;
    assert (ped_pend === pp) else begin
      n_fail++; $error("FAIL %s ped_pend: observed %b expected %b", tag, ped_pend, pp);
    end
    n_assert++;
    assert (ped_ack === ack) else begin
      n_fail++; $error("FAIL %s ped_ack: observed %b expected %b", tag, ped_ack, ack);
    end
    n_assert++;
    assert (emerg_act === ea) else begin
      n_fail++; $error("FAIL %s emerg_act: observed %b expected %b", tag, emerg_act, ea);
    end
  endtask

  task automatic sc(input string tag, input logic [2:0] ph, input logic [CW-1:0] rem,
                    input logic pp, input logic ack);
    step();
    check(tag, ph, rem, pp, ack);
  endtask

  initial begin
    rst_n = 1'b0; tick_en = 1'b1; ped_req = 1'b1; emerg_req = 1'b1;

    // Reset dominates active requests
    sc("rst0", 0, 2, 0, 0);
    sc("rst1", 0, 2, 0, 0);
    sc("rst2", 0, 2, 0, 0);
    rst_n = 1'b1; ped_req = 1'b0; emerg_req = 1'b0;

    // Normal cycle: RED 3, GREEN 4, YELLOW 2
    sc("red_a", 0, 1, 0, 0);
    sc("red_b", 0, 0, 0, 0);
    sc("grn_a", 2, 3, 0, 0);
    sc("grn_b", 2, 2, 0, 0);
    sc("grn_c", 2, 1, 0, 0);
    sc("grn_d", 2, 0, 0, 0);
    sc("yel_a", 3, 1, 0, 0);
    sc("yel_b", 3, 0, 0, 0);
    sc("red2_a", 0, 2, 0, 0);
    sc("red2_b", 0, 1, 0, 0);
    sc("red2_c", 0, 0, 0, 0);
    sc("grn2_a", 2, 3, 0, 0);

    // Pedestrian pulse in GREEN, served after next RED
    ped_req = 1'b1;
    sc("ped_lat", 2, 2, 1, 0);
    ped_req = 1'b0;
    sc("ped_g1", 2, 1, 1, 0);
    sc("ped_g0", 2, 0, 1, 0);
    sc("ped_y1", 3, 1, 1, 0);
    sc("ped_y0", 3, 0, 1, 0);
    sc("ped_r2", 0, 2, 1, 0);
    sc("ped_r1", 0, 1, 1, 0);
    sc("ped_r0", 0, 0, 1, 0);
    sc("ped_in", 1, 1, 0, 1);
    sc("ped_p0", 1, 0, 0, 0);
    sc("ped_out", 2, 3, 0, 0);

    // Preempt from GREEN at remain 2: full YELLOW then EMERGENCY, held
    sc("pg_g2", 2, 2, 0, 0);
    emerg_req = 1'b1;
    sc("pg_y1", 3, 1, 0, 0);
    sc("pg_y0", 3, 0, 0, 0);
    sc("pg_e1", 4, 1, 0, 0);
    sc("pg_e0", 4, 0, 0, 0);
    sc("pg_hold1", 4, 0, 0, 0);
    sc("pg_hold2", 4, 0, 0, 0);
    sc("pg_hold3", 4, 0, 0, 0);
    sc("pg_hold4", 4, 0, 0, 0);
    emerg_req = 1'b0;
    sc("pg_exit", 0, 2, 0, 0);

    // Preempt from RED with a pending call; tick coincides with preempt
    ped_req = 1'b1;
    sc("pr_lat", 0, 1, 1, 0);
    ped_req = 1'b0; emerg_req = 1'b1;
    sc("pr_e1", 4, 1, 1, 0);
    emerg_req = 1'b0;
    sc("pr_e0", 4, 0, 1, 0);
    sc("pr_r2", 0, 2, 1, 0);
    sc("pr_r1", 0, 1, 1, 0);
    sc("pr_r0", 0, 0, 1, 0);
    sc("pr_ped", 1, 1, 0, 1);
    sc("pr_p0", 1, 0, 0, 0);
    sc("pr_grn", 2, 3, 0, 0);

    // ped_req on the RED-ending cycle is latched, not served
    sc("ls_g2", 2, 2, 0, 0);
    sc("ls_g1", 2, 1, 0, 0);
    sc("ls_g0", 2, 0, 0, 0);
    sc("ls_y1", 3, 1, 0, 0);
    sc("ls_y0", 3, 0, 0, 0);
    sc("ls_r2", 0, 2, 0, 0);
    sc("ls_r1", 0, 1, 0, 0);
    sc("ls_r0", 0, 0, 0, 0);
    ped_req = 1'b1;
    sc("ls_grn", 2, 3, 1, 0);
    ped_req = 1'b0;

    // Tick gating: tick every 4th clk stretches RED to 12 clks
    rst_n = 1'b0;
    sc("tg_rst", 0, 2, 0, 0);
    rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick_en = (k % 4 == 0);
      step();
      if (k == 12) check("tg_grn", 2, 3, 0, 0);
      else check("tg_red", 0, (k < 4) ? 4'd2 : (k < 8) ? 4'd1 : 4'd0, 0, 0);
    end

    // Emergency between ticks still preempts on the next clk
    rst_n = 1'b0; tick_en = 1'b1;
    sc("te_rst", 0, 2, 0, 0);
    rst_n = 1'b1; tick_en = 1'b0;
    sc("te_r_a", 0, 2, 0, 0);
    emerg_req = 1'b1;
    sc("te_emg", 4, 1, 0, 0);
    emerg_req = 1'b0;
    sc("te_hold", 4, 1, 0, 0);

    // Illegal phase code recovers to RED
    @(negedge clk);
    force dut.phase_q = 3'd6;
    #1;
    release dut.phase_q;
    sc("illegal", 0, 2, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
